// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   - Opcode field constants (HALT and NOP) and the NOP instruction word
//     injected into IF/ID on reset, flush and bubbles.
//   - Fetch state encoding.
//   - Helper that extracts the opcode field from an instruction word.
package fetch_stage_pkg;

  localparam logic [4:0]  OPC_HALT = 5'b00000;
  localparam logic [4:0]  OPC_NOP  = 5'b00001;
  localparam logic [15:0] NOP_WORD = {OPC_NOP, 11'b0};  // 16'h0800

  // FETCH : requesting imem at PC every cycle
  // HOLD  : one fetched instruction parked in the skid buffer, waiting for stall to drop
  // HALTED: fetch stopped; only a redirect or reset restarts it
  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_HOLD   = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

  function automatic logic [4:0] opcode_of(input logic [15:0] instr);
    return instr[15:11];
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for an instruction (and its PC+2) that returned
// from memory while decode was stalled.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   load                capture in_instr / in_pc_plus2, mark full
//   drain               entry consumed, mark empty
//   clear               discard entry (flush); wins over load and drain
//   in_instr, in_pc_plus2    data to capture
//   out_instr, out_pc_plus2  held data
//   out_valid           entry holds a real instruction
module fetch_skid_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        drain,
  input  logic        clear,
  input  logic [15:0] in_instr,
  input  logic [15:0] in_pc_plus2,
  output logic [15:0] out_instr,
  output logic [15:0] out_pc_plus2,
  output logic        out_valid
);

  logic        valid_q, valid_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] pc_plus2_q, pc_plus2_d;

  always_comb begin
    valid_d    = valid_q;
    instr_d    = instr_q;
    pc_plus2_d = pc_plus2_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d    = 1'b1;
      instr_d    = in_instr;
      pc_plus2_d = in_pc_plus2;
    end else if (drain) begin
      valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= 1'b0;
    else     valid_q <= valid_d;
  end

  // NOTE: the data registers carry no reset; valid_q alone decides whether
  // their contents mean anything, so resetting them would only cost routing.
  always_ff @(posedge clk) begin
    instr_q    <= instr_d;
    pc_plus2_q <= pc_plus2_d;
  end

  assign out_instr    = instr_q;
  assign out_pc_plus2 = pc_plus2_q;
  assign out_valid    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Owns the PC, requests instructions from a variable-latency memory, parks one
// instruction in a skid buffer when decode stalls, flushes on EX redirect and
// stops on HALT.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   imem_req, imem_addr      fetch request / address (address is always PC)
//   imem_rdy, imem_data      instruction valid for the current address this cycle
//   stall                    hold IF/ID and PC
//   redirect, redirect_pc    flush and reload PC (highest priority)
//   ifid_instr, ifid_pc_plus2, ifid_valid   IF/ID register towards decode
//   halted                   fetch stopped
//   err                      sticky misaligned-redirect flag
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [15:0] NOP_INSTR   = NOP_WORD,
  parameter logic [4:0]  HALT_OPCODE = OPC_HALT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_rdy,
  input  logic [15:0] imem_data,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] ifid_instr,
  output logic [15:0] ifid_pc_plus2,
  output logic        ifid_valid,
  output logic        halted,
  output logic        err
);

  fetch_state_e state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic [15:0]  instr_q, instr_d;
  logic [15:0]  pc_plus2_q, pc_plus2_d;
  logic         valid_q, valid_d;
  logic         err_q, err_d;

  logic [15:0]  pc_plus2;
  logic         skid_load, skid_drain, skid_clear, skid_valid;
  logic [15:0]  skid_instr, skid_pc_plus2;

  assign pc_plus2 = pc_q + 16'd2;  // wraps FFFE -> 0000 by width

  fetch_skid_buf u_skid (
    .clk          (clk),
    .rst          (rst),
    .load         (skid_load),
    .drain        (skid_drain),
    .clear        (skid_clear),
    .in_instr     (imem_data),
    .in_pc_plus2  (pc_plus2),
    .out_instr    (skid_instr),
    .out_pc_plus2 (skid_pc_plus2),
    .out_valid    (skid_valid)
  );

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc_plus2_d = pc_plus2_q;
    valid_d    = valid_q;
    err_d      = err_q;
    skid_load  = 1'b0;
    skid_drain = 1'b0;
    skid_clear = 1'b0;

    if (redirect) begin
      // Flush beats everything: skid and any same-cycle imem_data are dropped.
      skid_clear = 1'b1;
      instr_d    = NOP_INSTR;
      valid_d    = 1'b0;
      pc_d       = {redirect_pc[15:1], 1'b0};
      if (redirect_pc[0]) begin
        err_d   = 1'b1;
        state_d = ST_HALTED;
      end else begin
        state_d = ST_FETCH;
      end
    end else begin
      unique case (state_q)
        ST_FETCH: begin
          if (imem_rdy && !stall) begin
            instr_d    = imem_data;
            pc_plus2_d = pc_plus2;
            valid_d    = 1'b1;
            pc_d       = pc_plus2;
            if (opcode_of(imem_data) == HALT_OPCODE) state_d = ST_HALTED;
          end else if (imem_rdy) begin
            // Decode is stalled: park the instruction so the request is not lost.
            skid_load = 1'b1;
            pc_d      = pc_plus2;
            state_d   = ST_HOLD;
          end else if (!stall) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
          end
        end
        ST_HOLD: begin
          if (!stall && skid_valid) begin
            skid_drain = 1'b1;
            instr_d    = skid_instr;
            pc_plus2_d = skid_pc_plus2;
            valid_d    = 1'b1;
            state_d    = (opcode_of(skid_instr) == HALT_OPCODE) ? ST_HALTED : ST_FETCH;
          end
        end
        ST_HALTED: begin
          if (!stall) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
          end
        end
        default: state_d = ST_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_FETCH;
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
      pc_plus2_q <= 16'h0000;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_plus2_q <= pc_plus2_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  // Gated by rst so no request is seen while reset is held.
  assign imem_req      = !rst && (state_q == ST_FETCH);
  assign imem_addr     = pc_q;
  assign ifid_instr    = instr_q;
  assign ifid_pc_plus2 = pc_plus2_q;
  assign ifid_valid    = valid_q;
  assign halted        = (state_q == ST_HALTED);
  assign err           = err_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rdy;
  logic [15:0] imem_data;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc_plus2;
  logic        ifid_valid;
  logic        halted;
  logic        err;

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdy      (imem_rdy),
    .imem_data     (imem_data),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .ifid_instr    (ifid_instr),
    .ifid_pc_plus2 (ifid_pc_plus2),
    .ifid_valid    (ifid_valid),
    .halted        (halted),
    .err           (err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: what decode should see, described by the stage's rules.
  localparam logic [15:0] NOP = 16'h0800;
  logic [15:0] m_pc, m_instr, m_pc2;
  logic        m_valid, m_stopped, m_err;
  logic [31:0] m_parked[$];  // {instr, pc_plus2} waiting for stall to drop

  function automatic void model_reset();
    m_pc = 16'h0000; m_instr = NOP; m_pc2 = 16'h0000;
    m_valid = 1'b0; m_stopped = 1'b0; m_err = 1'b0;
    m_parked.delete();
  endfunction

  function automatic void model_clock(input logic rdy, input logic [15:0] data,
                                      input logic stl, input logic rd, input logic [15:0] rpc);
    logic [31:0] e;
    if (rd) begin
      m_parked.delete();
      m_instr = NOP; m_valid = 1'b0;
      m_pc = rpc & 16'hFFFE;
      m_stopped = rpc[0];
      if (rpc[0]) m_err = 1'b1;
    end else if (m_parked.size() != 0) begin
      if (!stl) begin
        e = m_parked.pop_front();
        m_instr = e[31:16]; m_pc2 = e[15:0]; m_valid = 1'b1;
        m_stopped = (e[31:27] == 5'd0);
      end
    end else if (m_stopped) begin
      if (!stl) begin m_instr = NOP; m_valid = 1'b0; end
    end else if (rdy && !stl) begin
      m_instr = data; m_pc2 = m_pc + 16'd2; m_valid = 1'b1;
      m_pc = m_pc + 16'd2;
      m_stopped = (data[15:11] == 5'd0);
    end else if (rdy) begin
      m_parked.push_back({data, 16'(m_pc + 16'd2)});
      m_pc = m_pc + 16'd2;
    end else if (!stl) begin
      m_instr = NOP; m_valid = 1'b0;
    end
  endfunction

  task automatic compare_all(input string where);
    check({where, ".imem_req"},   32'(imem_req),   32'(!m_stopped && m_parked.size() == 0));
    check({where, ".imem_addr"},  32'(imem_addr),  32'(m_pc));
    check({where, ".ifid_instr"}, 32'(ifid_instr), 32'(m_instr));
    check({where, ".ifid_valid"}, 32'(ifid_valid), 32'(m_valid));
    if (m_valid) check({where, ".ifid_pc_plus2"}, 32'(ifid_pc_plus2), 32'(m_pc2));
    check({where, ".halted"},     32'(halted),     32'(m_stopped));
    check({where, ".err"},        32'(err),        32'(m_err));
  endtask

  task automatic step(input string where, input logic rdy, input logic [15:0] data,
                      input logic stl, input logic rd, input logic [15:0] rpc);
    imem_rdy = rdy; imem_data = data; stall = stl; redirect = rd; redirect_pc = rpc;
    @(posedge clk);
    model_clock(rdy, data, stl, rd, rpc);
    #1;
    compare_all(where);
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    check("rst.imem_req_low", 32'(imem_req), 32'd0);
    model_reset();
    @(posedge clk); #1;
    check("rst.ifid_pc_plus2", 32'(ifid_pc_plus2), 32'd0);
    rst = 1'b0;
    #1;
    compare_all("rst");
  endtask

  initial begin
    rst = 1'b0; imem_rdy = 1'b0; imem_data = '0; stall = 1'b0;
    redirect = 1'b0; redirect_pc = '0;
    @(posedge clk); #1;
    do_reset();

    // Straight-line fetch, then bubbles at 0004.
    step("seq0", 1, 16'h1111, 0, 0, 0);
    step("seq1", 1, 16'h2222, 0, 0, 0);
    repeat (3) step("bubble", 0, 16'(($urandom & 32'hFFFF) | 32'h8000), 0, 0, 0);
    step("seq2", 1, 16'h3333, 0, 0, 0);
    step("seq3", 1, 16'h5555, 0, 0, 0);

    // Stall in the cycle 4321 returns at 0008; released after two cycles.
    step("skid_load", 1, 16'h4321, 1, 0, 0);
    step("skid_hold", 0, 16'h9999, 1, 0, 0);
    step("skid_drain", 0, 16'h9999, 0, 0, 0);
    check("skid.instr", 32'(ifid_instr), 32'h4321);
    check("skid.pc_plus2", 32'(ifid_pc_plus2), 32'h000A);
    check("skid.next_addr", 32'(imem_addr), 32'h000A);

    // Redirect under stall with an instruction parked: it must never surface.
    step("flush_load", 1, 16'h7777, 1, 0, 0);
    step("flush", 0, 16'h6666, 1, 1, 16'h0100);
    check("flush.addr", 32'(imem_addr), 32'h0100);
    repeat (2) step("flush_after", 0, 16'h6666, 0, 0, 0);

    // HALT at 0010, then restart at 0020.
    step("to_0010", 0, 16'h0, 0, 1, 16'h0010);
    step("halt_fetch", 1, 16'h0000, 0, 0, 0);
    check("halt.in_ifid", 32'({ifid_instr, ifid_valid, halted}), 32'h0000_0003);
    repeat (2) step("halted", 1, 16'h2468, 0, 0, 0);
    step("resume", 0, 16'h0, 0, 1, 16'h0020);
    check("resume.addr", 32'(imem_addr), 32'h0020);
    step("resume_fetch", 1, 16'hA5A5, 0, 0, 0);

    // Misaligned redirect: sticky error until reset.
    step("misalign", 0, 16'h0, 0, 1, 16'h0031);
    check("misalign.addr", 32'(imem_addr), 32'h0030);
    step("realign", 0, 16'h0, 0, 1, 16'h0040);
    repeat (2) step("after_misalign", 1, 16'h1357, 0, 0, 0);
    check("err.sticky", 32'(err), 32'd1);
    do_reset();
    check("err.cleared", 32'(err), 32'd0);

    // PC wrap.
    step("to_fffe", 0, 16'h0, 0, 1, 16'hFFFE);
    step("wrap", 1, 16'h1234, 0, 0, 0);
    check("wrap.addr", 32'(imem_addr), 32'h0000);
    check("wrap.pc_plus2", 32'(ifid_pc_plus2), 32'h0000);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      logic        r_rdy, r_stl, r_rd;
      logic [15:0] r_data, r_pc;
      r_rdy  = ($urandom_range(0, 9) < 7);
      r_stl  = ($urandom_range(0, 9) < 3);
      r_rd   = ($urandom_range(0, 19) == 0);
      r_data = 16'($urandom);
      r_pc   = 16'($urandom);
      if ($urandom_range(0, 3) != 0) r_pc[0] = 1'b0;
      step("rand", r_rdy, r_data, r_stl, r_rd, r_pc);
      if ($urandom_range(0, 199) == 0) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
